// File: rtl/ula_pkg.sv
// Shared types and widths for the arbitrated ULA datapath.
package ula_pkg;

  localparam int unsigned NBITS_OP = 3;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_OR} op_t;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

endpackage

// File: rtl/ula_3bits.sv
// Combinational ULA: add/sub/and/or on zero-extended operands, one extra result bit.
module ula_3bits #(
  parameter int unsigned NBITS_OP = ula_pkg::NBITS_OP
) (
  input  logic [NBITS_OP-1:0] a,
  input  logic [NBITS_OP-1:0] b,
  input  ula_pkg::op_t        op,
  output logic [NBITS_OP:0]   saida
);
  import ula_pkg::*;

  logic [NBITS_OP:0] a_ext;
  logic [NBITS_OP:0] b_ext;

  assign a_ext = {1'b0, a};
  assign b_ext = {1'b0, b};

  // Extra bit carries on add and wraps as two's complement on sub.
  always_comb begin
    saida = '0;
    unique case (op)
      OP_ADD: saida = a_ext + b_ext;
      OP_SUB: saida = a_ext - b_ext;
      OP_AND: saida = a_ext & b_ext;
      OP_OR:  saida = a_ext | b_ext;
    endcase
  end

endmodule

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one ULA between two requesters, with latched operands,
// a programmable execute delay and a registered result returned over valid/ready.
module ula_arbiter #(
  parameter int unsigned NBITS_OP    = ula_pkg::NBITS_OP,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic                     clk_2,
  input  logic                     reset,
  input  logic [1:0]               req_valid,
  input  logic [1:0][NBITS_OP-1:0] req_a,
  input  logic [1:0][NBITS_OP-1:0] req_b,
  input  logic [1:0][1:0]          req_op,
  output logic [1:0]               req_ready,
  output logic [1:0]               rsp_valid,
  input  logic [1:0]               rsp_ready,
  output logic [NBITS_OP:0]        rsp_result,
  output logic                     rsp_id,
  output logic                     busy
);
  import ula_pkg::*;

  localparam logic [3:0] CntLoad = 4'(EXEC_CYCLES - 1);

  state_t                state_q;
  logic                  last_grant_q;
  logic [3:0]            cnt_q;
  logic [NBITS_OP-1:0]   a_q;
  logic [NBITS_OP-1:0]   b_q;
  op_t                   op_q;
  logic [NBITS_OP:0]     rsp_result_q;
  logic                  rsp_id_q;
  logic [1:0]            rsp_valid_q;

  logic                  winner;
  logic                  accept;
  logic [NBITS_OP:0]     ula_out;

  // A lone request wins outright; on contention the requester not granted last time wins.
  always_comb begin
    winner = ~last_grant_q;
    if (req_valid == 2'b01) begin
      winner = 1'b0;
    end else if (req_valid == 2'b10) begin
      winner = 1'b1;
    end
    req_ready = 2'b00;
    if ((state_q == S_IDLE) && (req_valid != 2'b00)) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign accept = |(req_valid & req_ready);

  ula_3bits #(
    .NBITS_OP (NBITS_OP)
  ) u_ula (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .saida (ula_out)
  );

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= 4'd0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_ADD;
      rsp_result_q <= '0;
      rsp_id_q     <= 1'b0;
      rsp_valid_q  <= 2'b00;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q          <= req_a[winner];
            b_q          <= req_b[winner];
            op_q         <= op_t'(req_op[winner]);
            rsp_id_q     <= winner;
            last_grant_q <= winner;
            cnt_q        <= CntLoad;
            state_q      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rsp_result_q <= ula_out;
            rsp_valid_q  <= rsp_id_q ? 2'b10 : 2'b01;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          // Only the owner's ready completes the response.
          if (rsp_ready[rsp_id_q]) begin
            rsp_valid_q <= 2'b00;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_id     = rsp_id_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ula_arbiter.sv
// Self-checking bench for ula_arbiter: two instances (1 and 4 execute cycles) on shared inputs.
module tb_ula_arbiter;

  logic            clk_2 = 1'b0;
  logic            reset;
  logic [1:0]      req_valid;
  logic [1:0][2:0] req_a;
  logic [1:0][2:0] req_b;
  logic [1:0][1:0] req_op;
  logic [1:0]      rsp_ready;

  logic [1:0] rr1, rv1, rr4, rv4;
  logic [3:0] res1, res4;
  logic       id1, id4, busy1, busy4;

  bit         sel4;
  logic [1:0] obs_rr, obs_rv;
  logic [3:0] obs_res;
  logic       obs_id, obs_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int lg;

  always #5 clk_2 = ~clk_2;

  ula_arbiter #(.NBITS_OP(3), .EXEC_CYCLES(1)) dut1 (
    .clk_2(clk_2), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_ready(rr1), .rsp_valid(rv1), .rsp_ready(rsp_ready),
    .rsp_result(res1), .rsp_id(id1), .busy(busy1)
  );

  ula_arbiter #(.NBITS_OP(3), .EXEC_CYCLES(4)) dut4 (
    .clk_2(clk_2), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_ready(rr4), .rsp_valid(rv4), .rsp_ready(rsp_ready),
    .rsp_result(res4), .rsp_id(id4), .busy(busy4)
  );

  always_comb begin
    obs_rr   = sel4 ? rr4 : rr1;
    obs_rv   = sel4 ? rv4 : rv1;
    obs_res  = sel4 ? res4 : res1;
    obs_id   = sel4 ? id4 : id1;
    obs_busy = sel4 ? busy4 : busy1;
  end

  function automatic logic [3:0] ref_ula(input int a, input int b, input int op);
    case (op)
      0:       return 4'((a + b) % 16);
      1:       return 4'((a - b + 16) % 16);
      2:       return 4'(a & b);
      default: return 4'(a | b);
    endcase
  endfunction

  task automatic step();
    @(posedge clk_2);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    step();
    step();
    reset = 1'b0;
    lg    = 1;
  endtask

  task automatic wait_rsp(output int cyc, output bit ok);
    cyc = 0;
    while (obs_rv == 2'b00 && cyc < 20) begin
      step();
      cyc++;
    end
    ok = (obs_rv != 2'b00);
  endtask

  task automatic test_reset();
    sel4      = 1'b0;
    reset     = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    step();
    step();
    n_checks++;
    if (obs_rv !== 2'b00 || obs_res !== 4'd0 || obs_id !== 1'b0 || obs_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rv=%b res=%h id=%b busy=%b expected 00 0 0 0",
               obs_rv, obs_res, obs_id, obs_busy);
    end
    n_checks++;
    if (obs_rr !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_first_grant: got req_ready=%b expected 01", obs_rr);
    end
    req_valid = 2'b10;
    #1;
    n_checks++;
    if (obs_rr !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_lone_req1: got req_ready=%b expected 10", obs_rr);
    end
    req_valid = 2'b00;
    reset     = 1'b0;
    lg        = 1;
  endtask

  task automatic test_single();
    int  cyc;
    bit  ok;
    sel4 = 1'b0;
    do_reset();
    req_valid = 2'b01;
    req_a[0]  = 3'd3;
    req_b[0]  = 3'd2;
    req_op[0] = 2'b00;
    #1;
    n_checks++;
    if (obs_rr !== 2'b01) begin
      n_fail++;
      $display("FAIL single_ready: got %b expected 01", obs_rr);
    end
    step();
    req_valid = 2'b00;
    wait_rsp(cyc, ok);
    n_checks++;
    if (!ok || cyc != 1) begin
      n_fail++;
      $display("FAIL single_latency: got %0d cycles (ok=%0d) expected 1", cyc, ok);
    end
    n_checks++;
    if (obs_rv !== 2'b01 || obs_res !== 4'b0101 || obs_id !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rsp: got rv=%b res=%b id=%b expected 01 0101 0", obs_rv, obs_res,
               obs_id);
    end
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    n_checks++;
    if (obs_busy !== 1'b0 || obs_rv !== 2'b00 || obs_res !== 4'b0101) begin
      n_fail++;
      $display("FAIL single_done: got busy=%b rv=%b res=%b expected 0 00 0101", obs_busy,
               obs_rv, obs_res);
    end
  endtask

  task automatic test_boundaries();
    int         ta[5]  = '{1, 7, 0, 5, 5};
    int         tb_[5] = '{2, 7, 7, 3, 3};
    int         to[5]  = '{1, 0, 1, 2, 3};
    logic [3:0] te[5]  = '{4'b1111, 4'b1110, 4'b1001, 4'b0001, 4'b0111};
    sel4 = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      int w;
      int cyc;
      bit ok;
      w             = int'($urandom_range(0, 1));
      req_valid     = (w == 1) ? 2'b10 : 2'b01;
      req_a[w]      = 3'(ta[k]);
      req_b[w]      = 3'(tb_[k]);
      req_op[w]     = 2'(to[k]);
      step();
      req_valid = 2'b00;
      wait_rsp(cyc, ok);
      n_checks++;
      if (!ok || obs_res !== te[k] || obs_id !== 1'(w)) begin
        n_fail++;
        $display("FAIL boundary_%0d: got res=%b id=%b ok=%0d expected res=%b id=%0d", k,
                 obs_res, obs_id, ok, te[k], w);
      end
      rsp_ready = 2'b11;
      step();
      rsp_ready = 2'b00;
    end
  endtask

  task automatic test_both_valid();
    int order[4] = '{0, 1, 0, 1};
    sel4 = 1'b0;
    do_reset();
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    for (int g = 0; g < 4; g++) begin
      int cyc;
      bit ok;
      n_checks++;
      if (obs_rr !== (2'b01 << order[g])) begin
        n_fail++;
        $display("FAIL both_grant_%0d: got req_ready=%b expected requester %0d", g, obs_rr,
                 order[g]);
      end
      step();
      wait_rsp(cyc, ok);
      n_checks++;
      if (!ok || obs_id !== 1'(order[g]) || obs_rv !== (2'b01 << order[g])) begin
        n_fail++;
        $display("FAIL both_rsp_%0d: got id=%b rv=%b expected id=%0d", g, obs_id, obs_rv,
                 order[g]);
      end
      step();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
  endtask

  task automatic test_backpressure();
    int cyc;
    bit ok;
    sel4 = 1'b0;
    do_reset();
    req_valid = 2'b01;
    req_a[0]  = 3'd5;
    req_b[0]  = 3'd3;
    req_op[0] = 2'b00;
    step();
    req_valid = 2'b11;
    wait_rsp(cyc, ok);
    for (int k = 0; k < 5; k++) begin
      rsp_ready = {1'(k % 2 == 0), 1'b0};
      step();
      n_checks++;
      if (obs_rv !== 2'b01 || obs_res !== 4'b1000 || obs_busy !== 1'b1 || obs_rr !== 2'b00) begin
        n_fail++;
        $display("FAIL backpressure_%0d: got rv=%b res=%b busy=%b rr=%b expected 01 1000 1 00",
                 k, obs_rv, obs_res, obs_busy, obs_rr);
      end
    end
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    n_checks++;
    if (obs_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: got busy=%b expected 0", obs_busy);
    end
  endtask

  task automatic test_reset_mid_exec();
    int cyc;
    bit ok;
    sel4 = 1'b1;
    do_reset();
    req_valid = 2'b01;
    req_a[0]  = 3'd1;
    req_b[0]  = 3'd1;
    req_op[0] = 2'b00;
    step();
    req_valid = 2'b00;
    wait_rsp(cyc, ok);
    n_checks++;
    if (!ok || cyc != 4 || obs_res !== 4'd2) begin
      n_fail++;
      $display("FAIL exec4_latency: got %0d cycles res=%h expected 4 cycles res=2", cyc, obs_res);
    end
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    req_a[0]  = 3'd3;
    req_b[0]  = 3'd3;
    step();
    req_valid = 2'b00;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (obs_rv !== 2'b00 || obs_res !== 4'd0 || obs_id !== 1'b0 || obs_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midexec_reset: got rv=%b res=%h id=%b busy=%b expected 00 0 0 0", obs_rv,
               obs_res, obs_id, obs_busy);
    end
    req_valid = 2'b11;
    #1;
    n_checks++;
    if (obs_rr !== 2'b01) begin
      n_fail++;
      $display("FAIL midexec_regrant: got req_ready=%b expected 01", obs_rr);
    end
    req_valid = 2'b00;
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if (obs_rv !== 2'b00) begin
        n_fail++;
        $display("FAIL midexec_no_rsp_%0d: got rv=%b expected 00", k, obs_rv);
      end
    end
  endtask

  task automatic test_operand_change();
    int cyc;
    bit ok;
    sel4 = 1'b1;
    do_reset();
    req_valid = 2'b01;
    req_a[0]  = 3'd2;
    req_b[0]  = 3'd1;
    req_op[0] = 2'b00;
    step();
    req_valid = 2'b00;
    req_a[0]  = 3'd6;
    wait_rsp(cyc, ok);
    n_checks++;
    if (!ok || obs_res !== 4'd3) begin
      n_fail++;
      $display("FAIL operand_change: got res=%h ok=%0d expected 3", obs_res, ok);
    end
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
  endtask

  task automatic test_random_ops(input bit use4, input int n);
    int exp_cycles;
    sel4       = use4;
    exp_cycles = use4 ? 4 : 1;
    do_reset();
    for (int t = 0; t < n; t++) begin
      logic [1:0] v;
      logic [3:0] exp_res;
      int         w;
      int         cyc;
      int         hold;
      bit         ok;
      v         = 2'($urandom_range(0, 3));
      req_valid = v;
      for (int i = 0; i < 2; i++) begin
        req_a[i]  = 3'($urandom);
        req_b[i]  = 3'($urandom);
        req_op[i] = 2'($urandom);
      end
      rsp_ready = 2'b00;
      #1;
      if (v == 2'b00) begin
        n_checks++;
        if (obs_rr !== 2'b00) begin
          n_fail++;
          $display("FAIL rand_idle_ready: got %b expected 00", obs_rr);
        end
        step();
        continue;
      end
      w       = (v == 2'b11) ? (1 - lg) : (v[1] ? 1 : 0);
      exp_res = ref_ula(int'(req_a[w]), int'(req_b[w]), int'(req_op[w]));
      n_checks++;
      if (obs_rr !== (2'b01 << w)) begin
        n_fail++;
        $display("FAIL rand_grant: got req_ready=%b valid=%b expected requester %0d", obs_rr, v,
                 w);
      end
      step();
      lg        = w;
      req_valid = 2'($urandom);
      req_a     = 6'($urandom);
      req_b     = 6'($urandom);
      req_op    = 4'($urandom);
      n_checks++;
      if (obs_busy !== 1'b1 || obs_rv !== 2'b00 || obs_rr !== 2'b00) begin
        n_fail++;
        $display("FAIL rand_exec: got busy=%b rv=%b rr=%b expected 1 00 00", obs_busy, obs_rv,
                 obs_rr);
      end
      wait_rsp(cyc, ok);
      n_checks++;
      if (!ok || cyc != exp_cycles) begin
        n_fail++;
        $display("FAIL rand_latency: got %0d cycles ok=%0d expected %0d", cyc, ok, exp_cycles);
      end
      n_checks++;
      if (obs_rv !== (2'b01 << w) || obs_res !== exp_res || obs_id !== 1'(w)) begin
        n_fail++;
        $display("FAIL rand_rsp: got rv=%b res=%b id=%b expected owner %0d res=%b", obs_rv,
                 obs_res, obs_id, w, exp_res);
      end
      hold = int'($urandom_range(0, 3));
      for (int k = 0; k < hold; k++) begin
        rsp_ready       = 2'b00;
        rsp_ready[1-w]  = 1'($urandom);
        step();
        n_checks++;
        if (obs_rv !== (2'b01 << w) || obs_res !== exp_res) begin
          n_fail++;
          $display("FAIL rand_hold: got rv=%b res=%b expected owner %0d res=%b", obs_rv, obs_res,
                   w, exp_res);
        end
      end
      rsp_ready    = 2'b00;
      rsp_ready[w] = 1'b1;
      step();
      rsp_ready = 2'b00;
      n_checks++;
      if (obs_busy !== 1'b0 || obs_rv !== 2'b00 || obs_res !== exp_res || obs_id !== 1'(w)) begin
        n_fail++;
        $display("FAIL rand_done: got busy=%b rv=%b res=%b id=%b expected 0 00 %b %0d", obs_busy,
                 obs_rv, obs_res, obs_id, exp_res, w);
      end
    end
    req_valid = 2'b00;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected completion");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    sel4      = 1'b0;
    lg        = 1;
    test_reset();
    test_single();
    test_boundaries();
    test_both_valid();
    test_backpressure();
    test_reset_mid_exec();
    test_operand_change();
    test_random_ops(1'b0, 40);
    test_random_ops(1'b1, 30);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
